conv3x3_stream: RTL and testbench

//  Parametrised 3x3 streaming image filter for the video pipeline (SDRAM read -> filter -> edge/display).

---
 rtl/vid_pkg.sv | 19 +
 rtl/line_buf.sv | 24 ++
 rtl/conv3x3_stream.sv | 177 +++++++++++++++++
 tb/tb_conv3x3_stream.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared video pipeline definitions: filter mode encodings, pipeline latency and sideband payload.
package vid_pkg;

    localparam int unsigned LAT = 4;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_GAUSS  = 2'd1,
        MODE_SOBEL  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef struct packed {
        logic vld;
        logic sop;
        logic eop;
    } side_t;

endpackage

// File: rtl/line_buf.sv
// One line of pixel history: simple-dual-port RAM sharing one address, old data visible while writing.
module line_buf #(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned DEPTH = 640,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wd,
    output logic [DW-1:0] q_c
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wd;
        end
    end

    assign q_c = mem[addr];

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming filter (bypass / Gaussian / Sobel) with two line buffers and a fixed 4-cycle latency.
module conv3x3_stream
    import vid_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned IMG_W       = 640,
    parameter int unsigned BORDER_PASS = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = 16;
    localparam int unsigned GW    = DW + 2;
    localparam int unsigned SW    = DW + 4;
    localparam int unsigned XW    = DW + 3;

    logic [COL_W-1:0] col, cur_col;
    logic [ROW_W-1:0] row, cur_row;
    mode_e            mode_q, mode_cur;
    logic             border_c;
    logic [DW-1:0]    lb0_q, lb1_q;

    logic [DW-1:0]    win [3][3];
    mode_e            s1_mode, s2_mode, s3_mode;
    logic             s1_border, s2_border, s3_border;

    logic [GW-1:0]    gcol [3];
    logic signed [DW:0] dcol [3];
    logic [DW-1:0]    s2_raw, s2_ctr, s3_raw, s3_ctr;

    logic signed [XW-1:0] gx_c, gy_c;
    logic [XW-1:0]    ax_c, ay_c, mag;
    logic [SW-1:0]    gsum;

    logic [DW-1:0]    gauss_px, sobel_px, edge_px, res_c;
    side_t            side_pipe [LAT];

    // A sop pixel always sits at (0,0) and takes the mode presented with it
    always_comb begin
        cur_col  = din_sop ? '0 : col;
        cur_row  = din_sop ? '0 : row;
        mode_cur = din_sop ? mode_e'(mode) : mode_q;
        border_c = (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            mode_q <= MODE_BYPASS;
        end else if (din_vld) begin
            if (din_sop) begin
                mode_q <= mode_e'(mode);
            end
            if (cur_col == COL_W'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row != {ROW_W{1'b1}}) ? cur_row + ROW_W'(1) : cur_row;
            end else begin
                col <= cur_col + COL_W'(1);
                row <= cur_row;
            end
        end
    end

    line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (
        .clk  (clk),
        .en   (din_vld),
        .addr (cur_col),
        .wd   (din),
        .q_c  (lb0_q)
    );

    line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
        .clk  (clk),
        .en   (din_vld),
        .addr (cur_col),
        .wd   (lb0_q),
        .q_c  (lb1_q)
    );

    // S1: window rows top..bottom = r-2..r, columns left..right = c-2..c
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            s1_mode   <= MODE_BYPASS;
            s1_border <= 1'b0;
        end else if (din_vld) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1_q;
            win[1][2] <= lb0_q;
            win[2][2] <= din;
            s1_mode   <= mode_cur;
            s1_border <= border_c;
        end
    end

    // S2: per-column 1-2-1 sums (Gaussian and gx) and bottom-minus-top differences (gy)
    always_ff @(posedge clk) begin
        for (int j = 0; j < 3; j++) begin
            gcol[j] <= GW'(win[0][j]) + GW'({win[1][j], 1'b0}) + GW'(win[2][j]);
            dcol[j] <= $signed({1'b0, win[2][j]}) - $signed({1'b0, win[0][j]});
        end
        s2_mode   <= s1_mode;
        s2_border <= s1_border;
        s2_raw    <= win[2][2];
        s2_ctr    <= win[1][1];
    end

    always_comb begin
        gx_c = $signed({1'b0, gcol[2]}) - $signed({1'b0, gcol[0]});
        gy_c = $signed({{2{dcol[0][DW]}}, dcol[0]})
             + $signed({dcol[1][DW], dcol[1], 1'b0})
             + $signed({{2{dcol[2][DW]}}, dcol[2]});
        ax_c = gx_c[XW-1] ? XW'(-gx_c) : XW'(gx_c);
        ay_c = gy_c[XW-1] ? XW'(-gy_c) : XW'(gy_c);
    end

    // S3: full Gaussian sum and Sobel magnitude
    always_ff @(posedge clk) begin
        gsum      <= SW'(gcol[0]) + SW'({gcol[1], 1'b0}) + SW'(gcol[2]);
        mag       <= ax_c + ay_c;
        s3_mode   <= s2_mode;
        s3_border <= s2_border;
        s3_raw    <= s2_raw;
        s3_ctr    <= s2_ctr;
    end

    always_comb begin
        gauss_px = DW'((gsum + SW'(8)) >> 4);
        sobel_px = (mag > XW'((1 << DW) - 1)) ? {DW{1'b1}} : mag[DW-1:0];
        edge_px  = (BORDER_PASS != 0) ? s3_ctr : '0;
        case (s3_mode)
            MODE_GAUSS: res_c = s3_border ? edge_px : gauss_px;
            MODE_SOBEL: res_c = s3_border ? edge_px : sobel_px;
            default:    res_c = s3_raw;
        endcase
    end

    // S4: output register; sideband travels alongside in a LAT-deep delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
            for (int i = 0; i < LAT; i++) begin
                side_pipe[i] <= '0;
            end
        end else begin
            dout         <= res_c;
            side_pipe[0] <= '{vld: din_vld, sop: din_vld & din_sop, eop: din_vld & din_eop};
            for (int i = 1; i < LAT; i++) begin
                side_pipe[i] <= side_pipe[i-1];
            end
        end
    end

    assign dout_vld = side_pipe[LAT-1].vld;
    assign dout_sop = side_pipe[LAT-1].sop;
    assign dout_eop = side_pipe[LAT-1].eop;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream on an 8x4 image: frame-level reference plus hand-computed spot values.
module tb_conv3x3_stream;

    localparam int W = 8;
    localparam int H = 4;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [7:0] din;
    logic       din_vld, din_sop, din_eop;
    logic [7:0] dout;
    logic       dout_vld, dout_sop, dout_eop;

    always #5 clk = ~clk;

    conv3x3_stream #(.DW(8), .IMG_W(W), .BORDER_PASS(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    typedef struct {
        int val;
        bit sop;
        bit eop;
        int cyc;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   img [0:H-1][0:W-1];
    int   pix [0:H+1][0:W-1];
    bit   rv  [0:H+1];
    int   obs [0:NPIX-1];
    int   oidx = 0;
    int   vld_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference rows: index 0,1 = last two rows of the previous frame, 2..5 = current frame
    function automatic int px(input int r, input int c);
        return pix[r+2][c];
    endfunction

    function automatic int model(input int r, input int c, input int md);
        int s, gx, gy, cr, cc, wi;
        if (md == 0 || md == 3) return img[r][c];
        if (r < 2 || c < 2) begin
            if (c >= 1) begin cr = r - 1; cc = c - 1; end
            else        begin cr = r - 2; cc = W - 1; end
            if (!rv[cr+2]) return -1;
            return pix[cr+2][cc];
        end
        if (md == 1) begin
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1) * px(r-2+i, c-2+j);
            return (s + 8) >>> 4;
        end
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            wi = (i == 1) ? 2 : 1;
            gx += wi * (px(r-2+i, c) - px(r-2+i, c-2));
            gy += wi * (px(r, c-2+i) - px(r-2, c-2+i));
        end
        s = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        return (s > 255) ? 255 : s;
    endfunction

    task automatic start_frame(input int kind);
        for (int c = 0; c < W; c++) begin
            pix[0][c] = pix[4][c];
            pix[1][c] = pix[5][c];
        end
        rv[0] = rv[4];
        rv[1] = rv[5];
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0: img[r][c] = 100;
                    1: img[r][c] = (r == 2 && c == 2) ? 255 : 0;
                    2: img[r][c] = (c >= W/2) ? 200 : 0;
                    default: img[r][c] = (r * W + c) * 7 + 3;
                endcase
                pix[r+2][c] = img[r][c];
            end
            rv[r+2] = 1'b1;
        end
    endtask

    task automatic step_idle();
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din     = 8'd0;
    endtask

    task automatic send_pix(input int r, input int c, input int md, input bit sop, input bit eop);
        exp_t e;
        @(posedge clk);
        #1;
        din     = 8'(img[r][c]);
        din_vld = 1'b1;
        din_sop = sop;
        din_eop = eop;
        e.val = model(r, c, md);
        e.sop = sop;
        e.eop = eop;
        e.cyc = cyc + 4;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input int kind, input int md, input bit gap,
                              input int chg_at, input int chg_md, input int abort_at);
        mode = 2'(md);
        start_frame(kind);
        for (int k = 0; k < NPIX; k++) begin
            if (k == abort_at) return;
            if (k == chg_at) mode = 2'(chg_md);
            send_pix(k / W, k % W, md, k == 0, k == NPIX - 1);
            if (gap && k != NPIX - 1) begin
                step_idle();
                step_idle();
            end
        end
        step_idle();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check(tag, exp_q.size(), 0);
        step_idle();
    endtask

    always @(negedge clk) begin
        if (dout_vld) begin
            if (dout_sop) begin
                oidx    = 0;
                vld_cnt = 0;
            end
            if (oidx < NPIX) obs[oidx] = dout;
            oidx++;
            vld_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_vld", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("latency", cyc, mon_e.cyc);
                if (mon_e.val >= 0) check("pixel", int'(dout), mon_e.val);
                check("sop", int'(dout_sop), int'(mon_e.sop));
                check("eop", int'(dout_eop), int'(mon_e.eop));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < H + 2; i++) begin
            rv[i] = 1'b0;
            for (int c = 0; c < W; c++) pix[i][c] = 0;
        end
        rst = 1'b1; mode = 2'd0; din = 8'd0;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", int'(dout), 0);
        check("rst_vld",  int'(dout_vld), 0);
        check("rst_sop",  int'(dout_sop), 0);
        check("rst_eop",  int'(dout_eop), 0);
        rst = 1'b0;

        // Flat 100, Gaussian, two frames back to back (eop directly followed by sop)
        send_frame(0, 1, 1'b0, -1, 0, -1);
        send_frame(0, 1, 1'b0, -1, 0, -1);
        drain("drain_flat");
        check("flat_vld_count", vld_cnt, 32);
        check("flat_r0c0", obs[0], 100);
        check("flat_r1c1", obs[9], 100);
        check("flat_r2c2", obs[18], 100);
        check("flat_r3c7", obs[31], 100);

        // Single 255 at (2,2)
        send_frame(1, 1, 1'b0, -1, 0, -1);
        drain("drain_impulse");
        check("imp_ctr22", obs[27], 64);
        check("imp_ctr12", obs[19], 32);
        check("imp_ctr11", obs[18], 16);
        check("imp_zero",  obs[31], 0);

        // Vertical edge 0 | 200, Sobel
        send_frame(2, 2, 1'b0, -1, 0, -1);
        drain("drain_edge");
        check("edge_c4", obs[20], 255);
        check("edge_c5", obs[29], 255);
        check("flat_right", obs[22], 0);
        check("flat_left",  obs[26], 0);

        // Bypass with two idle cycles after every pixel
        send_frame(3, 0, 1'b1, -1, 0, -1);
        drain("drain_gap");
        check("gap_px5",  obs[5], 38);
        check("gap_px31", obs[31], 220);
        check("gap_vld_count", vld_cnt, 32);

        // Mode switched mid-frame is ignored until the next sop
        send_frame(2, 1, 1'b0, 10, 2, -1);
        drain("drain_mchg");
        check("mchg_gauss", obs[20], 50);
        send_frame(2, 2, 1'b0, -1, 0, -1);
        drain("drain_mnext");
        check("mnext_sobel", obs[20], 255);

        // Reset after 13 pixels of a frame
        send_frame(3, 1, 1'b0, -1, 0, 13);
        @(posedge clk);
        #1;
        rst = 1'b1;
        din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_vld",  int'(dout_vld), 0);
        check("midrst_sop",  int'(dout_sop), 0);
        check("midrst_eop",  int'(dout_eop), 0);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < H + 2; i++) rv[i] = 1'b0;
        step_idle();
        send_frame(3, 1, 1'b0, -1, 0, -1);
        drain("drain_postrst");
        check("postrst_ctr22", obs[27], 129);
        check("postrst_vld_count", vld_cnt, 32);

        repeat (8) step_idle();
        check("tail_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
